// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers of the MIPS datapath.
//
// Ports:
//   clock    - single clock, all state changes on the rising edge
//   reset    - synchronous, active-high; aborts any operation, clears HI/LO
//   start    - request; op/rs_data/rt_data are sampled on the same edge
//   op       - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 ignored
//   rs_data  - multiplicand / dividend / MTHI-MTLO source
//   rt_data  - multiplier / divisor
//   hi, lo   - architectural HI and LO registers
//   busy     - high while an operation is iterating or being sign-fixed
//   done     - one-cycle pulse when hi/lo carry a freshly finished result
//
// Operations move through IDLE -> RUN (WIDTH iterations) -> FIX -> DONE.
// Signed operands are reduced to magnitudes at capture and the signs are
// reapplied in FIX, so the RUN datapath is purely unsigned.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               sign_p_q, sign_p_d;
    logic               sign_r_q, sign_r_d;

    // Operand preparation. A signed divide by zero is captured raw with no
    // signs, so the unsigned restoring loop naturally yields an all-ones
    // quotient and the untouched dividend as remainder.
    logic             op_is_div, op_signed, div_zero, use_sign;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;

    always_comb begin
        op_is_div = (op == 3'd2) || (op == 3'd3);
        op_signed = (op == 3'd0) || (op == 3'd2);
        div_zero  = op_is_div && (rt_data == '0);
        use_sign  = op_signed && !div_zero;
        rs_neg    = use_sign && rs_data[WIDTH-1];
        rt_neg    = use_sign && rt_data[WIDTH-1];
        rs_mag    = rs_neg ? -rs_data : rs_data;
        rt_mag    = rt_neg ? -rt_data : rt_data;
    end

    // One iteration of each algorithm. Multiply keeps {partial, multiplier}
    // in acc and shifts right; divide keeps {remainder, dividend/quotient}
    // and shifts left, shifting quotient bits in at the bottom.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_cand;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_step, div_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};
        div_cand = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = div_cand >= {1'b0, opb_q};
        div_sub  = div_cand[WIDTH-1:0] - opb_q;
        div_step = {(div_ge ? div_sub : div_cand[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end

    // Sign restoration applied in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

    always_comb begin
        prod_fix = sign_p_q ? -acc_q : acc_q;
        quo_raw  = acc_q[WIDTH-1:0];
        rem_raw  = acc_q[2*WIDTH-1:WIDTH];
        quo_fix  = sign_p_q ? -quo_raw : quo_raw;
        rem_fix  = sign_r_q ? -rem_raw : rem_raw;
    end

    // Next-state logic. HI/LO change only on MTHI/MTLO or on the FIX->DONE
    // edge, so they hold their old value for the whole of RUN and FIX.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sign_p_d = sign_p_q;
        sign_r_d = sign_r_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (op <= 3'd3) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        is_div_d = op_is_div;
                        sign_p_d = rs_neg ^ rt_neg;
                        sign_r_d = rs_neg;
                        if (op_is_div) begin
                            acc_d = {{WIDTH{1'b0}}, rs_mag};
                            opb_d = rt_mag;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, rt_mag};
                            opb_d = rs_mag;
                        end
                    end else if (op == 3'd4) begin
                        hi_d = rs_data;
                    end else if (op == 3'd5) begin
                        lo_d = rs_data;
                    end
                end
            end
            RUN: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any partial result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sign_p_q <= 1'b0;
            sign_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sign_p_q <= sign_p_d;
            sign_r_q <= sign_r_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == RUN) || (state_q == FIX);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Outputs are sampled 1 time unit after each rising edge. A value visible
// just after edge k is what edge k+1 samples, so a result "at edge N+34"
// (start accepted at edge N) is first visible 33 edges after the accept.
module tb_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clock;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rsData;
    logic [WIDTH-1:0] rtData;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    int testsRun;
    int testsFailed;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rsData),
        .rt_data (rtData),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issues one request and waits (bounded) for done. lat is the number of
    // edges after the accepting edge at which done is first seen, -1 on
    // timeout. busyCnt counts samples with busy high, firstBusy is busy right
    // after the accept, held reports whether hi/lo stayed put until done.
    task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output int lat,
                          output int busyCnt, output logic firstBusy,
                          output logic held);
        logic [WIDTH-1:0] hiOld, loOld;
        @(negedge clock);
        hiOld  = hi;
        loOld  = lo;
        start  = 1'b1;
        op     = o;
        rsData = a;
        rtData = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        lat       = -1;
        busyCnt   = busy ? 1 : 0;
        firstBusy = busy;
        held      = (hi === hiOld) && (lo === loOld);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busyCnt++;
            if (hi !== hiOld || lo !== loOld) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        rsData = 32'd3;
        rtData = 32'd4;
        repeat (3) @(posedge clock);
        #1;
        testsRun++;
        if (hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_hi got %h want %h", hi, 32'h0); end
        testsRun++;
        if (lo !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_lo got %h want %h", lo, 32'h0); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        testsRun++;
        if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got %b want 0", done); end
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int lat, bc;
        logic fb, held;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, lat, bc, fb, held);
        testsRun++;
        if (lat != LAT) begin testsFailed++; $display("[TB] FAIL mult_latency got %0d want %0d", lat, LAT); end
        testsRun++;
        if (bc != LAT) begin testsFailed++; $display("[TB] FAIL mult_busy_cycles got %0d want %0d", bc, LAT); end
        testsRun++;
        if (!held) begin testsFailed++; $display("[TB] FAIL mult_hold got changed want held"); end
        testsRun++;
        if (hi !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL mult_hi got %h want %h", hi, 32'hFFFFFFFF); end
        testsRun++;
        if (lo !== 32'hFFFFFFEB) begin testsFailed++; $display("[TB] FAIL mult_lo got %h want %h", lo, 32'hFFFFFFEB); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mult_busy_in_done got %b want 0", busy); end
        @(posedge clock);
        #1;
        testsRun++;
        if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL mult_done_pulse got %b want 0", done); end
    endtask

    task automatic test_multu;
        int lat, bc;
        logic fb, held;
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, fb, held);
        testsRun++;
        if (lat != LAT) begin testsFailed++; $display("[TB] FAIL multu_latency got %0d want %0d", lat, LAT); end
        testsRun++;
        if (hi !== 32'hFFFFFFFE) begin testsFailed++; $display("[TB] FAIL multu_hi got %h want %h", hi, 32'hFFFFFFFE); end
        testsRun++;
        if (lo !== 32'h00000001) begin testsFailed++; $display("[TB] FAIL multu_lo got %h want %h", lo, 32'h1); end
        run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, fb, held);
        testsRun++;
        if (hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL mult_neg_hi got %h want %h", hi, 32'h0); end
        testsRun++;
        if (lo !== 32'h1) begin testsFailed++; $display("[TB] FAIL mult_neg_lo got %h want %h", lo, 32'h1); end
    endtask

    task automatic test_div;
        int lat, bc;
        logic fb, held;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, lat, bc, fb, held);
        testsRun++;
        if (lat != LAT) begin testsFailed++; $display("[TB] FAIL div_latency got %0d want %0d", lat, LAT); end
        testsRun++;
        if (lo !== 32'hFFFFFFFD) begin testsFailed++; $display("[TB] FAIL div_lo got %h want %h", lo, 32'hFFFFFFFD); end
        testsRun++;
        if (hi !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL div_hi got %h want %h", hi, 32'hFFFFFFFF); end
        run_op(3'd3, 32'd100, 32'd7, lat, bc, fb, held);
        testsRun++;
        if (lo !== 32'd14) begin testsFailed++; $display("[TB] FAIL divu_lo got %h want %h", lo, 32'd14); end
        testsRun++;
        if (hi !== 32'd2) begin testsFailed++; $display("[TB] FAIL divu_hi got %h want %h", hi, 32'd2); end
    endtask

    task automatic test_div_zero;
        int lat, bc;
        logic fb, held;
        run_op(3'd3, 32'd100, 32'd0, lat, bc, fb, held);
        testsRun++;
        if (lat != LAT) begin testsFailed++; $display("[TB] FAIL divz_latency got %0d want %0d", lat, LAT); end
        testsRun++;
        if (lo !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL divz_lo got %h want %h", lo, 32'hFFFFFFFF); end
        testsRun++;
        if (hi !== 32'h00000064) begin testsFailed++; $display("[TB] FAIL divz_hi got %h want %h", hi, 32'h64); end
        // Signed divide by zero keeps the dividend raw, no sign fix.
        run_op(3'd2, 32'hFFFFFFF9, 32'd0, lat, bc, fb, held);
        testsRun++;
        if (lo !== 32'hFFFFFFFF) begin testsFailed++; $display("[TB] FAIL divz_signed_lo got %h want %h", lo, 32'hFFFFFFFF); end
        testsRun++;
        if (hi !== 32'hFFFFFFF9) begin testsFailed++; $display("[TB] FAIL divz_signed_hi got %h want %h", hi, 32'hFFFFFFF9); end
    endtask

    task automatic test_overflow;
        int lat, bc;
        logic fb, held;
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, bc, fb, held);
        testsRun++;
        if (lo !== 32'h80000000) begin testsFailed++; $display("[TB] FAIL div_ovf_lo got %h want %h", lo, 32'h80000000); end
        testsRun++;
        if (hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL div_ovf_hi got %h want %h", hi, 32'h0); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic fb, held;
        bit seen;
        // MULT 5*5, with a DIVU request injected mid-RUN that must be ignored.
        @(negedge clock);
        start = 1'b1; op = 3'd0; rsData = 32'd5; rtData = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = -1;
        seen = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 6) begin
                start = 1'b1; op = 3'd3; rsData = 32'd9; rtData = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            if (done) begin lat = k; seen = 1; break; end
        end
        start = 1'b0;
        testsRun++;
        if (lat != LAT) begin testsFailed++; $display("[TB] FAIL b2b_ignored_latency got %0d want %0d", lat, LAT); end
        testsRun++;
        if (hi !== 32'h0) begin testsFailed++; $display("[TB] FAIL b2b_mult_hi got %h want %h", hi, 32'h0); end
        testsRun++;
        if (lo !== 32'd25) begin testsFailed++; $display("[TB] FAIL b2b_mult_lo got %h want %h", lo, 32'd25); end
        // Issued while still in DONE: accepted on the edge that leaves DONE.
        run_op(3'd3, 32'd9, 32'd3, lat, bc, fb, held);
        testsRun++;
        if (fb !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_first_busy got %b want 1", fb); end
        testsRun++;
        if (lat != LAT) begin testsFailed++; $display("[TB] FAIL b2b_latency got %0d want %0d", lat, LAT); end
        testsRun++;
        if (lo !== 32'd3) begin testsFailed++; $display("[TB] FAIL b2b_divu_lo got %h want %h", lo, 32'd3); end
        testsRun++;
        if (hi !== 32'd0) begin testsFailed++; $display("[TB] FAIL b2b_divu_hi got %h want %h", hi, 32'd0); end
    endtask

    task automatic test_mthi_mtlo;
        repeat (2) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = 3'd4; rsData = 32'h0000AAAA;
        @(posedge clock);
        #1;
        start = 1'b0;
        testsRun++;
        if (hi !== 32'h0000AAAA) begin testsFailed++; $display("[TB] FAIL mthi_hi got %h want %h", hi, 32'hAAAA); end
        @(negedge clock);
        start = 1'b1; op = 3'd5; rsData = 32'h00001234;
        @(posedge clock);
        #1;
        start = 1'b0;
        testsRun++;
        if (lo !== 32'h00001234) begin testsFailed++; $display("[TB] FAIL mtlo_lo got %h want %h", lo, 32'h1234); end
        testsRun++;
        if (hi !== 32'h0000AAAA) begin testsFailed++; $display("[TB] FAIL mtlo_hi_kept got %h want %h", hi, 32'hAAAA); end
        testsRun++;
        if (done !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mtlo_flags got done=%b busy=%b want 0 0", done, busy); end
        // op 6 is a no-op.
        @(negedge clock);
        start = 1'b1; op = 3'd6; rsData = 32'hDEADBEEF; rtData = 32'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        testsRun++;
        if (hi !== 32'h0000AAAA || lo !== 32'h00001234) begin testsFailed++; $display("[TB] FAIL op6_noop got hi=%h lo=%h want hi=%h lo=%h", hi, lo, 32'hAAAA, 32'h1234); end
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0) begin testsFailed++; $display("[TB] FAIL op6_flags got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_reset_mid;
        bit sawDone;
        @(negedge clock);
        start = 1'b1; op = 3'd0; rsData = 32'd3; rtData = 32'd4;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        testsRun++;
        if (hi !== 32'h0 || lo !== 32'h0) begin testsFailed++; $display("[TB] FAIL midreset_hilo got hi=%h lo=%h want 0 0", hi, lo); end
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_flags got busy=%b done=%b want 0 0", busy, done); end
        @(negedge clock);
        reset = 1'b0;
        sawDone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done || busy) sawDone = 1;
        end
        testsRun++;
        if (sawDone) begin testsFailed++; $display("[TB] FAIL midreset_no_done got activity want none"); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        rsData = '0;
        rtData = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_mthi_mtlo();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
